// File: rtl/osc_freq_counter.sv
// Gated rising-edge counter for the relaxation oscillator feedback pad.
// Optional OSC_DEGLITCH_EN rejects single-cycle synchronized pulses.
module osc_freq_counter #(
  parameter int GATE_CYCLES = 10000,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               osc_in,
  input  logic               start,
  input  logic               cont,
  output logic [COUNT_W-1:0] count,
  output logic               overflow,
  output logic               valid,
  output logic               busy
);

  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] C_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    LATCH
  } state_t;

  state_t             state;
  logic [TW-1:0]      timer;
  logic [COUNT_W-1:0] edge_cnt;
  logic               ovf_flag;
  logic [COUNT_W-1:0] cnt_nxt;
  logic               ovf_nxt;

  logic sync1, sync2, prev, lvl, edge_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= osc_in;
      sync2 <= sync1;
      prev  <= lvl;
    end
  end

`ifdef OSC_DEGLITCH_EN
  logic sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync3 <= 1'b0;
    else        sync3 <= sync2;
  end

  // prev doubles as the filtered level: hold it until two samples agree
  assign lvl = (sync2 == sync3) ? sync2 : prev;
`else
  assign lvl = sync2;
`endif

  assign edge_hit = lvl & ~prev;

  always_comb begin
    cnt_nxt = edge_cnt;
    ovf_nxt = ovf_flag;
    if (edge_hit) begin
      if (edge_cnt == C_MAX) ovf_nxt = 1'b1;
      else                   cnt_nxt = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && ena) begin
            state    <= GATE;
            busy     <= 1'b1;
            timer    <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
          end
        end
        GATE: begin
          if (!ena) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            edge_cnt <= cnt_nxt;
            ovf_flag <= ovf_nxt;
            timer    <= timer + 1'b1;
            // result is presented while in LATCH, so it includes this cycle
            if (timer == T_LAST) begin
              state    <= LATCH;
              count    <= cnt_nxt;
              overflow <= ovf_nxt;
              valid    <= 1'b1;
            end
          end
        end
        LATCH: begin
          if (cont && ena) begin
            state    <= GATE;
            timer    <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osc_freq_counter.sv
// Directed plus randomized bench for osc_freq_counter.
// Expected counts come from a timestamped queue of osc_in rises.
module tb_osc_freq_counter;

  localparam int G = 100;
`ifdef OSC_DEGLITCH_EN
  localparam int LAT = 3;
  localparam int PULSE_EXP = 0;
`else
  localparam int LAT = 2;
  localparam int PULSE_EXP = 10;
`endif

  logic clk, rst_n, ena, osc_in, start, cont;
  logic clk_en;
  logic [15:0] count16;
  logic [3:0]  count4;
  logic ovf16, valid16, busy16;
  logic ovf4, valid4, busy4;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rises[$];
  int mode = 0;
  int hi_len = 5, lo_len = 5;
  bit rnd = 0;

  osc_freq_counter #(.GATE_CYCLES(G), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in),
    .start(start), .cont(cont), .count(count16),
    .overflow(ovf16), .valid(valid16), .busy(busy16)
  );

  osc_freq_counter #(.GATE_CYCLES(G), .COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in),
    .start(start), .cont(cont), .count(count4),
    .overflow(ovf4), .valid(valid4), .busy(busy4)
  );

  initial begin
    clk = 0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // oscillator source: 0 static low, 1 square wave, 2 one-clk pulse every 10
  initial begin
    int ph;
    int len;
    logic was;
    ph = 0;
    len = 5;
    osc_in = 0;
    forever begin
      @(negedge clk);
      was = osc_in;
      if (mode == 0) begin
        osc_in = 0;
        ph = 0;
      end else if (mode == 1) begin
        ph++;
        if (ph >= len) begin
          ph = 0;
          osc_in = ~osc_in;
          if (rnd) len = int'($urandom_range(8, 2));
          else     len = osc_in ? hi_len : lo_len;
        end
      end else begin
        ph = (ph >= 9) ? 0 : ph + 1;
        osc_in = (ph == 0);
      end
      // a rise driven now is sampled at the next posedge
      if (osc_in && !was) begin
        if (mode != 2 || PULSE_EXP != 0) rises.push_back(cyc + 1);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_edges(input int s);
    int n = 0;
    foreach (rises[i])
      if (rises[i] >= s + 1 - LAT && rises[i] <= s + G - LAT) n++;
    return n;
  endfunction

  task automatic check_result(input string tag, input int s);
    int n;
    n = model_edges(s);
    check({tag, "_cnt16"}, 32'(count16), (n > 65535) ? 65535 : n);
    check({tag, "_ovf16"}, 32'(ovf16), 32'(n > 65535));
    check({tag, "_cnt4"}, 32'(count4), (n > 15) ? 15 : n);
    check({tag, "_ovf4"}, 32'(ovf4), 32'(n > 15));
    check({tag, "_valid4"}, 32'(valid4), 1);
  endtask

  task automatic do_start(output int s);
    @(negedge clk);
    start = 1;
    s = cyc + 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid16) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic count_valids(input int n, output int v);
    v = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid16 || valid4) v++;
    end
  endtask

  task automatic run_meas(input string tag);
    int s, at;
    do_start(s);
    wait_valid(at);
    check({tag, "_when"}, at, s + G);
    check_result(tag, s);
    check({tag, "_busy_at_valid"}, 32'(busy16), 1);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy16), 0);
    check({tag, "_valid_after"}, 32'(valid16), 0);
  endtask

  task automatic set_square(input int h, input int l);
    hi_len = h;
    lo_len = l;
    rnd = 0;
    mode = 1;
  endtask

  initial begin
    int s, at, v;
    logic [15:0] held;
    clk_en = 1;
    rst_n = 1;
    ena = 1;
    start = 0;
    cont = 0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count16), 0);
    check("rst_ovf", 32'(ovf16), 0);
    check("rst_valid", 32'(valid16), 0);
    check("rst_busy", 32'(busy16), 0);
    rst_n = 1;
    repeat (5) @(negedge clk);

    set_square(5, 5);
    repeat (15) @(negedge clk);
    run_meas("t1");
    check("t1_direct", 32'(count16), 10);

    set_square(2, 2);
    repeat (10) @(negedge clk);
    run_meas("t2");
    check("t2_sat4", 32'(count4), 15);
    check("t2_ovf4", 32'(ovf4), 1);
    mode = 0;
    repeat (10) @(negedge clk);
    run_meas("t2_static");
    check("t2_static_cnt4", 32'(count4), 0);
    check("t2_static_ovf4", 32'(ovf4), 0);

    set_square(10, 10);
    repeat (10) @(negedge clk);
    cont = 1;
    do_start(s);
    for (int k = 0; k < 3; k++) begin
      wait_valid(at);
      check("t3_when", at, s + G);
      check_result("t3", s);
      check("t3_direct", 32'(count16), 5);
      s = s + G + 1;
      if (k == 1) begin
        repeat (3) @(negedge clk);
        cont = 0;
      end
    end
    @(negedge clk);
    check("t3_idle", 32'(busy16), 0);
    count_valids(150, v);
    check("t3_no_more", v, 0);

    set_square(5, 5);
    held = count16;
    do_start(s);
    repeat (50) @(negedge clk);
    ena = 0;
    @(negedge clk);
    check("t4_abort_busy", 32'(busy16), 0);
    repeat (5) @(negedge clk);
    ena = 1;
    count_valids(150, v);
    check("t4_abort_novalid", v, 0);
    check("t4_abort_hold", 32'(count16), 32'(held));
    do_start(s);
    repeat (30) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_valid(at);
    check("t4_restart_when", at, s + G);
    check_result("t4", s);
    @(negedge clk);
    check("t4_busy_after", 32'(busy16), 0);
    count_valids(150, v);
    check("t4_no_extra", v, 0);

    mode = 0;
    repeat (10) @(negedge clk);
    do_start(s);
    repeat (40) @(negedge clk);
    clk_en = 0;
    #20 rst_n = 0;
    #2;
    check("t5_async_count", 32'(count16), 0);
    check("t5_async_busy", 32'(busy16), 0);
    check("t5_async_ovf", 32'(ovf16), 0);
    check("t5_async_valid", 32'(valid16), 0);
    #5 rst_n = 1;
    #5 clk_en = 1;
    repeat (5) @(negedge clk);
    rises.delete();
    set_square(5, 5);
    repeat (10) @(negedge clk);
    run_meas("t5");
    check("t5_direct", 32'(count16), 10);

    mode = 2;
    repeat (15) @(negedge clk);
    run_meas("t6_pulse");
    check("t6_pulse_direct", 32'(count16), PULSE_EXP);
    set_square(5, 5);
    repeat (15) @(negedge clk);
    run_meas("t6_square");
    check("t6_square_direct", 32'(count16), 10);

    rnd = 1;
    mode = 1;
    for (int k = 0; k < 6; k++) begin
      repeat (int'($urandom_range(20, 3))) @(negedge clk);
      run_meas("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
